// File: rtl/key_event_gen_if.sv
// key_event_gen_if: bundle between the button-conditioning path and its consumers.
//   debounced_sig  : debounced button level, 1 = pressed (sync to clk)
//   repeat_en      : 1 = auto-repeat allowed
//   press_pulse    : one-cycle pulse on press
//   release_pulse  : one-cycle pulse on release
//   repeat_pulse   : one-cycle pulse per auto-repeat tick
//   held           : level, high while the button is considered held
// master drives the button level and repeat_en; slave (key_event_gen) drives the events.
interface key_event_gen_if;
    logic debounced_sig;
    logic repeat_en;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output debounced_sig, repeat_en,
        input  press_pulse, release_pulse, repeat_pulse, held
    );

    modport slave (
        input  debounced_sig, repeat_en,
        output press_pulse, release_pulse, repeat_pulse, held
    );
endinterface

// File: rtl/key_event_gen.sv
// key_event_gen: turns a debounced button level into single-cycle press,
// release and auto-repeat events, plus a registered "held" level.
// Ports:
//   clk     : system clock, rising edge
//   resetn  : asynchronous active-low reset
//   kif     : key_event_gen_if.slave (debounced_sig, repeat_en in;
//             press_pulse, release_pulse, repeat_pulse, held out)
// Parameters:
//   REPEAT_DELAY  : cycles from press pulse to first repeat pulse (>=2)
//   REPEAT_PERIOD : cycles between subsequent repeat pulses (>=2)
module key_event_gen #(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input logic            clk,
    input logic            resetn,
    key_event_gen_if.slave kif
);
    localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_CNT) + 1;

    localparam logic [CW-1:0] DLY_TC = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_TC = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          sig_q;
    logic          rise, fall;
    logic          press_nxt, release_nxt, repeat_nxt;
    logic          press_q, release_q, repeat_q, held_q;

    assign rise = kif.debounced_sig & ~sig_q;
    assign fall = ~kif.debounced_sig & sig_q;

    // Counter only advances while repeat_en is high; dropping repeat_en
    // parks it at 0 so re-enabling restarts the interval from scratch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    press_nxt = 1'b1;
                    state_nxt = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (fall) begin
                    // release wins over a coincident terminal count
                    release_nxt = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = IDLE;
                end else if (!kif.repeat_en) begin
                    cnt_nxt = '0;
                end else if (cnt == ((state == DELAY) ? DLY_TC : PER_TC)) begin
                    repeat_nxt = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = REPEAT;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            sig_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sig_q     <= kif.debounced_sig;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            repeat_q  <= repeat_nxt;
            held_q    <= (state_nxt != IDLE);
        end
    end

    assign kif.press_pulse   = press_q;
    assign kif.release_pulse = release_q;
    assign kif.repeat_pulse  = repeat_q;
    assign kif.held          = held_q;
endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: directed checks of key_event_gen with REPEAT_DELAY=10,
// REPEAT_PERIOD=4. Edge 1 is the first rising edge after reset release.
// Outputs are compared as {press, release, repeat, held}.
module tb_key_event_gen;
    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    key_event_gen_if kif ();

    key_event_gen #(
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(4)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .kif   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {kif.press_pulse, kif.release_pulse, kif.repeat_pulse, kif.held};
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Holds reset for a few cycles with input low, checks quiet outputs,
    // then releases on a falling edge.
    task automatic apply_reset(input string tag);
        resetn = 1'b0;
        kif.debounced_sig = 1'b0;
        kif.repeat_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 check({tag, "_rst"}, outs(), 4'b0000);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Input high for edges rise_e..fall_e-1; repeat_en low for edges
    // off_e..on_e-1. Expected repeat edges come as a hand-written mask.
    task automatic run(input string tag, input int n, input int rise_e, input int fall_e,
                       input int off_e, input int on_e, input logic [63:0] rep_mask);
        logic [3:0] exp;
        for (int k = 1; k <= n; k++) begin
            kif.debounced_sig = (k >= rise_e) && (k < fall_e);
            kif.repeat_en     = !((k >= off_e) && (k < on_e));
            @(posedge clk);
            #1;
            exp = {(k == rise_e), (k == fall_e), rep_mask[k], (k >= rise_e) && (k < fall_e)};
            check($sformatf("%s_e%0d", tag, k), outs(), exp);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] m;
        checks = 0;
        failures = 0;
        resetn = 1'b0;
        kif.debounced_sig = 1'b0;
        kif.repeat_en = 1'b1;

        // idle: nothing happens for 20 cycles
        apply_reset("idle");
        run("idle", 20, 1000, 1000, 1000, 1000, 64'd0);

        // hold with repeat: press 5, repeats 15,19,23,27,31,35, release 36
        apply_reset("rep");
        m = (64'd1 << 15) | (64'd1 << 19) | (64'd1 << 23) | (64'd1 << 27)
          | (64'd1 << 31) | (64'd1 << 35);
        run("rep", 40, 5, 36, 1000, 1000, m);

        // same hold, repeat disabled throughout
        apply_reset("norep");
        run("norep", 40, 5, 36, 0, 1000, 64'd0);

        // fall on the terminal-count edge 19: release only
        apply_reset("tc");
        run("tc", 24, 5, 19, 1000, 1000, 64'd1 << 15);

        // repeat_en low for edges 13..20, back on at 21: next repeat at 30
        apply_reset("en");
        run("en", 36, 5, 32, 13, 21, 64'd1 << 30);

        // one-cycle input pulse: press 3, release 4
        apply_reset("blip");
        run("blip", 8, 3, 4, 1000, 1000, 64'd0);

        // reset mid-hold: outputs drop at once, fresh press after release
        apply_reset("mid");
        run("mid", 10, 5, 1000, 1000, 1000, 64'd0);
        kif.debounced_sig = 1'b1;
        #1 resetn = 1'b0;
        #1 check("mid_async", outs(), 4'b0000);
        repeat (2) begin
            @(posedge clk);
            #1 check("mid_inrst", outs(), 4'b0000);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1 check("mid_press", outs(), 4'b1001);
        @(posedge clk);
        #1 check("mid_hold", outs(), 4'b0001);
        @(negedge clk);
        kif.debounced_sig = 1'b0;
        @(posedge clk);
        #1 check("mid_release", outs(), 4'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
